// File: rtl/uart_pkg.sv
// Shared definitions for the UART sample receiver and related serial blocks.
package uart_pkg;

    // 100 MHz system clock at 115200 baud.
    localparam int CLKS_PER_BIT_DEF = 868;

    // Width of an assembled filter sample.
    localparam int SAMPLE_W = 16;

    // Receiver frame state.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous inputs.
// RST_VAL should match the idle level of the source so reset produces no false edge.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; the first stage may go metastable, the second is used.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_sample_rx.sv
// 8N1 UART receiver that pairs bytes (low byte first) into 16-bit samples.
// A bad stop bit drops the byte, resets byte pairing and waits for the line
// to return high, so a held-low line reports one framing error only.
module uart_sample_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rxSerial,
    output logic [SAMPLE_W-1:0] sampleOut,
    output logic                sampleValid,
    output logic                frameErr
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_s;
    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic [7:0]    lo_byte;
    logic          phase;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxSerial),
        .q   (rx_s)
    );

    // Frame state machine, byte pairing and registered output strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            lo_byte     <= '0;
            phase       <= 1'b0;
            sampleOut   <= '0;
            sampleValid <= 1'b0;
            frameErr    <= 1'b0;
        end else begin
            sampleValid <= 1'b0;
            frameErr    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                // Re-check the line mid start bit; a short low pulse is a glitch.
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt                <= '0;
                        shift_reg[bit_idx] <= rx_s;
                        bit_idx            <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // Leaving for IDLE at mid stop bit leaves half a bit of margin
                // before a back-to-back start edge.
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            if (!phase) begin
                                lo_byte <= shift_reg;
                                phase   <= 1'b1;
                            end else begin
                                sampleOut   <= {shift_reg, lo_byte};
                                sampleValid <= 1'b1;
                                phase       <= 1'b0;
                            end
                        end else begin
                            state    <= BREAK;
                            frameErr <= 1'b1;
                            phase    <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                BREAK: begin
                    if (rx_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_sample_rx.sv
// Scoreboard bench for uart_sample_rx at 16 clocks per bit.
module tb_uart_sample_rx;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rxSerial = 1'b1;
    logic [15:0] sampleOut;
    logic        sampleValid;
    logic        frameErr;

    int          tests = 0;
    int          fails = 0;
    int          ferr_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    logic        prev_v = 1'b0;
    logic        prev_f = 1'b0;

    always #5 clk = ~clk;

    uart_sample_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .rxSerial    (rxSerial),
        .sampleOut   (sampleOut),
        .sampleValid (sampleValid),
        .frameErr    (frameErr)
    );

    // Output monitor: pops the scoreboard on each strobe and checks strobe shape.
    always @(negedge clk) begin
        if (rst) begin
            if (sampleValid) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_sample got %h, none required", sampleOut);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (sampleOut !== mon_exp) begin
                        fails++;
                        $display("FAIL sample got %h required %h", sampleOut, mon_exp);
                    end
                end
                if (frameErr) begin
                    fails++;
                    $display("FAIL strobe_overlap got valid=1 ferr=1 required not both");
                end
                if (prev_v) begin
                    fails++;
                    $display("FAIL valid_width got 2+ cycles required 1");
                end
            end
            if (frameErr) begin
                ferr_cnt++;
                if (prev_f) begin
                    fails++;
                    $display("FAIL ferr_width got 2+ cycles required 1");
                end
            end
            prev_v = sampleValid;
            prev_f = frameErr;
        end else begin
            prev_v = 1'b0;
            prev_f = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_b);
        rxSerial = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rxSerial = b[i];
            repeat (CPB) @(posedge clk);
        end
        rxSerial = stop_b;
        repeat (CPB) @(posedge clk);
        rxSerial = 1'b1;
    endtask

    task automatic idle(input int n);
        rxSerial = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rxSerial = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (sampleOut !== 16'h0000) begin
            fails++; $display("FAIL reset_sample got %h required 0000", sampleOut);
        end
        tests++;
        if (sampleValid !== 1'b0) begin
            fails++; $display("FAIL reset_valid got %b required 0", sampleValid);
        end
        tests++;
        if (frameErr !== 1'b0) begin
            fails++; $display("FAIL reset_ferr got %b required 0", frameErr);
        end
        @(negedge clk);
        rst = 1'b1;
        idle(2 * CPB);
    endtask

    task automatic test_basic();
        int f0;
        f0 = ferr_cnt;
        exp_q.push_back(16'h1234);
        send_byte(8'h34, 1'b1);
        idle(CPB);
        send_byte(8'h12, 1'b1);
        idle(2 * CPB);
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL basic_pending got %0d left required 0", exp_q.size());
        end
        tests++;
        if (ferr_cnt - f0 != 0) begin
            fails++; $display("FAIL basic_ferr got %0d required 0", ferr_cnt - f0);
        end
    endtask

    task automatic test_glitch();
        int f0;
        f0 = ferr_cnt;
        rxSerial = 1'b0;
        repeat (4) @(posedge clk);
        idle(3 * CPB);
        tests++;
        if (ferr_cnt - f0 != 0) begin
            fails++; $display("FAIL glitch_ferr got %0d required 0", ferr_cnt - f0);
        end
        exp_q.push_back(16'h8001);
        send_byte(8'h01, 1'b1);
        send_byte(8'h80, 1'b1);
        idle(2 * CPB);
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL glitch_pending got %0d left required 0", exp_q.size());
        end
    endtask

    task automatic test_break();
        int f0;
        f0 = ferr_cnt;
        send_byte(8'h55, 1'b0);
        rxSerial = 1'b0;
        repeat (50) @(posedge clk);
        idle(2 * CPB);
        exp_q.push_back(16'hABCD);
        send_byte(8'hCD, 1'b1);
        send_byte(8'hAB, 1'b1);
        idle(2 * CPB);
        tests++;
        if (ferr_cnt - f0 != 1) begin
            fails++; $display("FAIL break_ferr got %0d required 1", ferr_cnt - f0);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL break_pending got %0d left required 0", exp_q.size());
        end
    endtask

    task automatic test_realign();
        int f0;
        f0 = ferr_cnt;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        idle(2 * CPB);
        tests++;
        if (ferr_cnt - f0 != 1) begin
            fails++; $display("FAIL realign_ferr got %0d required 1", ferr_cnt - f0);
        end
        exp_q.push_back(16'h4433);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        idle(2 * CPB);
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL realign_pending got %0d left required 0", exp_q.size());
        end
        tests++;
        if (sampleOut !== 16'h4433) begin
            fails++; $display("FAIL realign_hold got %h required 4433", sampleOut);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [8];
        int f0;
        f0 = ferr_cnt;
        bytes = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h01, 8'h02, 8'hFE, 8'h7F};
        for (int i = 0; i < 8; i += 2)
            exp_q.push_back({bytes[i+1], bytes[i]});
        for (int i = 0; i < 8; i++)
            send_byte(bytes[i], 1'b1);
        idle(2 * CPB);
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL b2b_pending got %0d left required 0", exp_q.size());
        end
        tests++;
        if (ferr_cnt - f0 != 0) begin
            fails++; $display("FAIL b2b_ferr got %0d required 0", ferr_cnt - f0);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] b;
        b = 8'h3C;
        idle(CPB);
        rxSerial = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            rxSerial = b[i];
            repeat (CPB) @(posedge clk);
        end
        rxSerial = b[4];
        repeat (CPB / 2) @(posedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (sampleOut !== 16'h0000) begin
            fails++; $display("FAIL midrst_sample got %h required 0000", sampleOut);
        end
        tests++;
        if (sampleValid !== 1'b0 || frameErr !== 1'b0) begin
            fails++; $display("FAIL midrst_strobes got valid=%b ferr=%b required 0 0", sampleValid, frameErr);
        end
        rxSerial = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(2 * CPB);
        exp_q.push_back(16'h5678);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        idle(2 * CPB);
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL midrst_pending got %0d left required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_realign();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_sample_rx.md
# uart_sample_rx

UART receiver front end for the filter datapath. It deserialises the 8N1 serial stream from the host and pairs received bytes, low byte first, into 16-bit signed samples. It presents each sample with a one-cycle valid strobe to the filter stage directly downstream. It also flags framing errors and realigns byte pairing after each one.

## Interface
Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200). Legal range is 4 or more.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous, active-low. Asserting it (0) resets all state immediately; release is synchronous to clk.
- rxSerial  in  1  raw serial line. It is asynchronous to clk and idles high.
- sampleOut  out  16  last assembled sample, {high byte, low byte}. Holds its value between strobes.
- sampleValid  out  1  one-cycle pulse when sampleOut is updated.
- frameErr  out  1  one-cycle pulse when a stop bit is sampled low.

## Operation
- rxSerial passes through a two-flop synchroniser before use. Both flops reset to 1. The synchronised value is called rxS.
- A bit counter of width $clog2(CLKS_PER_BIT) and a 3-bit bit index drive the state machine below.
- IDLE: when rxS = 0, go to START and clear the counter.
- START: count to CLKS_PER_BIT/2 − 1 (integer division).
  - If rxS is still 0, go to DATA with the counter cleared and bitIdx = 0.
  - Otherwise the low pulse was a glitch: return to IDLE with no output.
- DATA: at counter = CLKS_PER_BIT − 1, sample rxS into shiftReg[bitIdx] (LSB first) and clear the counter.
  - After bitIdx = 7 is sampled, go to STOP.
- STOP: at counter = CLKS_PER_BIT − 1, sample rxS.
  - 1: the byte is good. Pass it to pairing and go to IDLE.
  - 0: pulse frameErr, discard the byte, clear the pairing phase, and go to BREAK.
- BREAK: wait for rxS = 1, then go to IDLE. A held-low line therefore produces exactly one frameErr.
- Pairing: a 1-bit phase register, reset to 0.
  - Good byte with phase 0: store it in loByte, set phase to 1.
  - Good byte with phase 1: sampleOut ← {byte, loByte}, pulse sampleValid, set phase to 0.
- All outputs are registered.

## Timing
- Reset values: sampleOut = 0x0000, sampleValid = 0, frameErr = 0, state = IDLE, phase = 0, counter = 0, bitIdx = 0.
- Synchroniser latency: 2 cycles from a rxSerial edge to rxS.
- Let T0 be the first cycle with rxS = 0. Sample points, relative to T0:
  - start check at CLKS_PER_BIT/2
  - data bit k at CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT
  - stop bit at CLKS_PER_BIT/2 + 9·CLKS_PER_BIT
- sampleValid and frameErr assert on the cycle after the stop sample of the completing byte, and last exactly 1 cycle.
- Back-to-back frames (a start bit immediately after the stop bit) must be received. IDLE is entered while the line is still in the stop bit, well before the next falling edge.
- sampleValid and frameErr can never assert on the same cycle.
- No backpressure: the downstream stage must accept every strobe. Strobes are at least 20·CLKS_PER_BIT cycles apart.
- Reset asserted mid-frame abandons the frame and clears the phase. The next falling edge after release starts a fresh frame as the low byte.

## Structure
- Shared package uart_pkg holds:
  - the state enum {IDLE, START, DATA, STOP, BREAK}
  - the default CLKS_PER_BIT constant
  - the SAMPLE_W = 16 constant
- Sub-module sync_2ff (1-bit two-flop synchroniser with a reset-value parameter). It is instantiated once and is reusable by other clock-domain-crossing inputs.

## Test plan
All scenarios use CLKS_PER_BIT = 16.
- Send byte 0x34, then 0x12, with 1 bit of idle between them. Required: one sampleValid pulse with sampleOut = 0x1234, and frameErr stays 0.
- Drive a 4-cycle low glitch on an idle line. Required: no sampleValid, no frameErr, and the next two bytes 0x01, 0x80 yield 0x8001.
- Send 0x55 with its stop bit forced low, hold the line low for 50 cycles, then send 0xCD, 0xAB. Required: exactly one frameErr pulse, then sampleOut = 0xABCD.
- Send 0x11, then 0x22 framed with a bad stop bit, then 0x33, 0x44. Required: frameErr on the second byte and sampleOut = 0x4433; the 0x11 is dropped by the realignment.
- Send 8 bytes back-to-back with no idle gap: 0x00, 0xFF, 0xA5, 0x5A, 0x01, 0x02, 0xFE, 0x7F. Required: outputs 0xFF00, 0x5AA5, 0x0201, 0x7FFE.
- Assert rst during bit 4 of a low byte, release it, then send 0x78, 0x56. Required: all outputs return to their reset values immediately, and the next output is 0x5678.
